bist_session_manager: RTL and testbench

Sequencer that sits directly upstream of the BIST top level. On a single `run_req` it launches a BIST pass by pulsing `bist_start`, then watches `bist_end` and `signature_out`. It compares the captured signature against the golden value and retries on mismatch or timeout. Final pass/fail, attempt count and last signature are held for system software or a tester.

---
 rtl/bist_pkg.sv | 24 ++
 rtl/bist_session_manager_if.sv | 30 +++
 rtl/bist_watchdog.sv | 33 +++
 rtl/bist_session_manager.sv | 140 ++++++++++++++
 tb/tb_bist_session_manager.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bist_pkg.sv
// Shared BIST definitions: session FSM states, signature width, golden MISR value.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bist_pkg;

  localparam int BIST_SIG_W = 16;

  // Golden MISR signature; the BIST top-level pass/fail logic compares against the same value.
  localparam logic [BIST_SIG_W-1:0] BIST_GOLDEN_SIG = 16'h6BD2;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_END,
    CHECK,
    FINISH
  } bist_sess_state_t;

  // 2-bit increment that sticks at 3 instead of wrapping.
  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

endpackage

// File: rtl/bist_session_manager_if.sv
// Session-manager bus: run request / BIST handshake in, session status out.
// Latency: n/a (wires only).
// Backpressure: none; run_req is a level sampled only while the manager is idle.
// master: the session manager (drives bist_start and status).
// slave : system/tester and BIST top level (drive run_req, bist_end, signature_in).
interface bist_session_manager_if;
  import bist_pkg::*;

  logic                  run_req;
  logic                  bist_start;
  logic                  bist_end;
  logic [BIST_SIG_W-1:0] signature_in;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic                  timeout;
  logic [1:0]            attempts;
  logic [BIST_SIG_W-1:0] last_signature;

  modport master (
    input  run_req, bist_end, signature_in,
    output bist_start, busy, done, pass, timeout, attempts, last_signature
  );

  modport slave (
    output run_req, bist_end, signature_in,
    input  bist_start, busy, done, pass, timeout, attempts, last_signature
  );

endinterface

// File: rtl/bist_watchdog.sv
// Loadable down-counter used as the per-attempt BIST completion watchdog.
// Latency: load takes effect next edge; expired is a decode of the counter register.
// Backpressure: none; counts only while enable is high and stops at zero.
// Ports: clock, reset (sync, active-high), load, enable, expired.
module bist_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Loaded with N-1 so that zero is reached on the N-th cycle after launch.
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/bist_session_manager.sv
// BIST session sequencer: launches BIST, checks the MISR signature, retries on mismatch/timeout.
// Latency: run_req@N -> bist_start during N+1; bist_end rise@M -> done during M+2 (no retry).
// Backpressure: run_req is ignored while busy; no request queuing.
// Ports: clock, reset (sync, active-high), io (bist_session_manager_if.master).
// Build option: define BIST_SESSION_RETRY_EN to enable up to MAX_RETRIES re-launches;
// without it every session is a single attempt.
module bist_session_manager
  import bist_pkg::*;
#(
  parameter logic [BIST_SIG_W-1:0] SIGNATURE_VALID = BIST_GOLDEN_SIG,
  parameter int                    MAX_RETRIES     = 2,
  parameter int                    TIMEOUT_CYCLES  = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  bist_session_manager_if.master io
);

`ifdef BIST_SESSION_RETRY_EN
  localparam int RETRY_LIMIT = MAX_RETRIES;
`else
  localparam int RETRY_LIMIT = 0;
`endif

  // Internal launch counter sized for MAX_RETRIES+1 launches. Kept separate from the
  // saturating 2-bit attempts output so the retry decision stays exact at MAX_RETRIES=3.
  localparam int                TRY_W       = $clog2(MAX_RETRIES + 2);
  localparam logic [TRY_W-1:0]  RETRY_LIM_V = TRY_W'(RETRY_LIMIT);

  bist_sess_state_t      state;
  logic                  bist_start_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  pass_q;
  logic                  timeout_q;
  logic [1:0]            attempts_q;
  logic [TRY_W-1:0]      tries_q;
  logic [BIST_SIG_W-1:0] last_sig_q;
  logic                  bist_end_q;
  logic                  bist_end_rise;
  logic                  wd_expired;

  // Completion is an edge, so a level left high by a previous run never counts.
  assign bist_end_rise = io.bist_end & ~bist_end_q;

  bist_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .load    (state == LAUNCH),
    .enable  (state == WAIT_END),
    .expired (wd_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      bist_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      attempts_q   <= 2'd0;
      tries_q      <= '0;
      last_sig_q   <= '0;
      bist_end_q   <= 1'b0;
    end else begin
      bist_end_q   <= io.bist_end;
      bist_start_q <= 1'b0;
      done_q       <= 1'b0;

      case (state)
        IDLE: begin
          if (io.run_req) begin
            state        <= LAUNCH;
            bist_start_q <= 1'b1;
            busy_q       <= 1'b1;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            attempts_q   <= 2'd0;
            tries_q      <= '0;
          end
        end

        LAUNCH: begin
          attempts_q <= sat_inc2(attempts_q);
          tries_q    <= tries_q + 1'b1;
          state      <= WAIT_END;
        end

        WAIT_END: begin
          // Edge is checked first so it wins a same-cycle race with expiry.
          if (bist_end_rise) begin
            last_sig_q <= io.signature_in;
            state      <= CHECK;
          end else if (wd_expired) begin
            timeout_q <= 1'b1;
            state     <= CHECK;
          end
        end

        CHECK: begin
          // timeout_q guards against a golden value left over from an earlier attempt.
          if (!timeout_q && (last_sig_q == SIGNATURE_VALID)) begin
            pass_q <= 1'b1;
            done_q <= 1'b1;
            state  <= FINISH;
          end else if (tries_q <= RETRY_LIM_V) begin
            timeout_q    <= 1'b0;
            bist_start_q <= 1'b1;
            state        <= LAUNCH;
          end else begin
            done_q <= 1'b1;
            state  <= FINISH;
          end
        end

        FINISH: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign io.bist_start     = bist_start_q;
  assign io.busy           = busy_q;
  assign io.done           = done_q;
  assign io.pass           = pass_q;
  assign io.timeout        = timeout_q;
  assign io.attempts       = attempts_q;
  assign io.last_signature = last_sig_q;

endmodule

// File: tb/tb_bist_session_manager.sv
// Testbench for bist_session_manager: directed and random sessions against a session-level model.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_bist_session_manager;

  localparam int          T_A   = 1024;
  localparam int          T_B   = 16;
  localparam int          MAX_R = 2;
  localparam logic [15:0] GOLD  = 16'h6BD2;
`ifdef BIST_SESSION_RETRY_EN
  localparam int R_EFF = MAX_R;
`else
  localparam int R_EFF = 0;
`endif

  logic        clock    = 1'b0;
  logic        reset    = 1'b1;
  logic        run_req  = 1'b0;
  logic        bist_end = 1'b0;
  logic [15:0] sig_in   = 16'h0;

  always #5 clock = ~clock;

  bist_session_manager_if if_a ();
  bist_session_manager_if if_b ();

  assign if_a.run_req      = run_req;
  assign if_a.bist_end     = bist_end;
  assign if_a.signature_in = sig_in;
  assign if_b.run_req      = run_req;
  assign if_b.bist_end     = bist_end;
  assign if_b.signature_in = sig_in;

  bist_session_manager #(
    .SIGNATURE_VALID (GOLD),
    .MAX_RETRIES     (MAX_R),
    .TIMEOUT_CYCLES  (T_A)
  ) dut_a (
    .clock (clock),
    .reset (reset),
    .io    (if_a)
  );

  // Short-watchdog instance, only judged in the hung-BIST session.
  bist_session_manager #(
    .SIGNATURE_VALID (GOLD),
    .MAX_RETRIES     (MAX_R),
    .TIMEOUT_CYCLES  (T_B)
  ) dut_b (
    .clock (clock),
    .reset (reset),
    .io    (if_b)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  // Per-attempt BIST response: delay in edges from the bist_start edge to the edge that
  // first samples bist_end high (0 = never), and the signature presented with it.
  int          resp_d   [4];
  logic [15:0] resp_sig [4];
  logic [15:0] last_a = 16'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic set_resp(input int d0, input logic [15:0] s0, input int d1, input logic [15:0] s1);
    resp_d[0] = d0; resp_sig[0] = s0;
    resp_d[1] = d1; resp_sig[1] = s1;
    resp_d[2] = 0;  resp_sig[2] = 16'h0;
    resp_d[3] = 0;  resp_sig[3] = 16'h0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    run_req  = 1'b0;
    bist_end = 1'b0;
    step();
    step();
    reset  = 1'b0;
    last_a = 16'h0;
  endtask

  // Session outcome from the rules: an attempt completes iff its edge lands within
  // [2, t+1] edges of launch; it then costs d+1 cycles to the next launch/done, else t+2.
  function automatic void model_session(input int t, input int r, input logic [15:0] prev,
                                        output int n_att, output bit p, output bit to,
                                        output logic [15:0] lsig, output int dur);
    bit ok;
    bit stop;
    n_att = 0; p = 1'b0; to = 1'b0; lsig = prev; dur = 0; stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!stop) begin
        ok = (resp_d[i] >= 2) && (resp_d[i] <= t + 1);
        n_att++;
        dur += ok ? resp_d[i] + 1 : t + 2;
        if (ok) begin
          lsig = resp_sig[i];
          to   = 1'b0;
        end else begin
          to = 1'b1;
        end
        if (ok && (resp_sig[i] == GOLD)) begin
          p    = 1'b1;
          stop = 1'b1;
        end else if (n_att > r) begin
          stop = 1'b1;
        end
      end
    end
  endfunction

  task automatic run_session(input bit stale, input bit poke, input bit chk_b);
    int          s, a, cnt, guard;
    int          first_a, done_a, n_start_a, n_done_a;
    int          first_b, done_b, n_start_b, n_done_b;
    int          e_att, e_dur, eb_att, eb_dur;
    bit          e_pass, e_to, eb_pass, eb_to;
    logic [15:0] e_sig, eb_sig;

    model_session(T_A, R_EFF, last_a, e_att, e_pass, e_to, e_sig, e_dur);
    model_session(T_B, R_EFF, 16'h0, eb_att, eb_pass, eb_to, eb_sig, eb_dur);

    first_a = -1; done_a = -1; n_start_a = 0; n_done_a = 0;
    first_b = -1; done_b = -1; n_start_b = 0; n_done_b = 0;
    a = -1; cnt = 0; guard = 0;
    bist_end = stale;
    sig_in   = 16'($urandom);
    s        = cyc;
    run_req  = 1'b1;

    while ((guard < 6000) && !((done_a >= 0) && (cyc >= done_a + 3))) begin
      step();
      guard++;
      run_req = 1'b0;
      if (if_a.bist_start) begin
        n_start_a++;
        if (first_a < 0) begin
          first_a = cyc;
          check("busy_at_launch", if_a.busy, 1);
        end
        a++;
        cnt = 0;
        if (!(stale && (a == 0))) bist_end = 1'b0;
        sig_in = 16'($urandom);
      end else if ((a >= 0) && (a < 4)) begin
        cnt++;
        if (stale && (a == 0) && (resp_d[0] != 0) && (cnt == resp_d[0] - 5)) bist_end = 1'b0;
        if ((resp_d[a] != 0) && (cnt == resp_d[a] - 1)) begin
          bist_end = 1'b1;
          sig_in   = resp_sig[a];
        end
        if (poke && (a == 0) && (cnt == 5)) run_req = 1'b1;
      end
      if (if_a.done) begin
        n_done_a++;
        done_a = cyc;
      end
      if (if_b.bist_start) begin
        n_start_b++;
        if (first_b < 0) first_b = cyc;
      end
      if (if_b.done) begin
        n_done_b++;
        done_b = cyc;
      end
    end

    check("done_seen",           done_a >= 0, 1);
    check("first_start_latency", first_a, s + 1);
    check("start_count",         n_start_a, e_att);
    check("done_count",          n_done_a, 1);
    check("done_cycle",          done_a, s + 1 + e_dur);
    check("pass",                if_a.pass, e_pass);
    check("timeout",             if_a.timeout, e_to);
    check("attempts",            if_a.attempts, (e_att > 3) ? 3 : e_att);
    check("last_signature",      if_a.last_signature, e_sig);
    check("busy_idle",           if_a.busy, 0);
    last_a = e_sig;

    if (chk_b) begin
      check("b_first_start",    first_b, s + 1);
      check("b_start_count",    n_start_b, eb_att);
      check("b_done_count",     n_done_b, 1);
      check("b_done_cycle",     done_b, s + 1 + eb_dur);
      check("b_pass",           if_b.pass, eb_pass);
      check("b_timeout",        if_b.timeout, eb_to);
      check("b_attempts",       if_b.attempts, (eb_att > 3) ? 3 : eb_att);
      check("b_last_signature", if_b.last_signature, eb_sig);
    end
  endtask

  initial begin
    int          n;
    logic [15:0] v;

    // Reset values.
    reset = 1'b1;
    step();
    step();
    check("rst_bist_start",     if_a.bist_start, 0);
    check("rst_busy",           if_a.busy, 0);
    check("rst_done",           if_a.done, 0);
    check("rst_pass",           if_a.pass, 0);
    check("rst_timeout",        if_a.timeout, 0);
    check("rst_attempts",       if_a.attempts, 0);
    check("rst_last_signature", if_a.last_signature, 0);
    reset = 1'b0;
    step();

    // Good run.
    set_resp(300, GOLD, 0, 16'h0);
    run_session(1'b0, 1'b0, 1'b0);

    // Bad signature, then good.
    set_resp(100, 16'h1234, 80, GOLD);
    run_session(1'b0, 1'b0, 1'b0);

    // bist_end left high before run_req must not count as completion.
    set_resp(40, GOLD, 0, 16'h0);
    run_session(1'b1, 1'b0, 1'b0);

    // Edge on the very cycle the watchdog reaches zero: edge wins.
    set_resp(T_A + 1, GOLD, 0, 16'h0);
    run_session(1'b0, 1'b0, 1'b0);

    // One cycle too late: timeout, then a good retry.
    set_resp(T_A + 2, GOLD, 10, GOLD);
    run_session(1'b0, 1'b0, 1'b0);

    // run_req pulsed mid-session is ignored.
    set_resp(60, GOLD, 0, 16'h0);
    run_session(1'b0, 1'b1, 1'b0);

    // Reset while waiting for bist_end.
    bist_end = 1'b0;
    run_req  = 1'b1;
    step();
    run_req = 1'b0;
    repeat (50) step();
    check("busy_in_wait_end", if_a.busy, 1);
    reset = 1'b1;
    step();
    check("mid_rst_bist_start",     if_a.bist_start, 0);
    check("mid_rst_busy",           if_a.busy, 0);
    check("mid_rst_done",           if_a.done, 0);
    check("mid_rst_pass",           if_a.pass, 0);
    check("mid_rst_timeout",        if_a.timeout, 0);
    check("mid_rst_attempts",       if_a.attempts, 0);
    check("mid_rst_last_signature", if_a.last_signature, 0);
    reset  = 1'b0;
    last_a = 16'h0;
    n = 0;
    repeat (40) begin
      step();
      if (if_a.done) n++;
    end
    check("no_done_after_reset", n, 0);
    set_resp(50, GOLD, 0, 16'h0);
    run_session(1'b0, 1'b0, 1'b0);

    // Hung BIST: both watchdog lengths.
    do_reset();
    set_resp(0, 16'h0, 0, 16'h0);
    run_session(1'b0, 1'b0, 1'b1);

    // Random sessions.
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 4; i++) begin
        resp_d[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(8, 500));
        if ($urandom_range(0, 1) == 1) begin
          resp_sig[i] = GOLD;
        end else begin
          v = 16'($urandom);
          if (v == GOLD) v = v ^ 16'h0001;
          resp_sig[i] = v;
        end
      end
      run_session(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
